// File: rtl/addsub_acc_unit.sv
// Registered add/subtract unit with running accumulator, optional signed
// overflow rules and saturation, and a single-entry valid/ready output stage.
module addsub_acc_unit #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned SIGNED   = 0,
    parameter int unsigned SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic [WIDTH-1:0] acc
);

    typedef enum logic [1:0] {
        OpSub    = 2'b00,
        OpAdd    = 2'b01,
        OpAccSub = 2'b10,
        OpLoad   = 2'b11
    } op_e;

    localparam bit IsSigned = (SIGNED != 0);
    localparam bit DoSat    = (SATURATE != 0);

    // Extreme values used when clamping
    localparam logic [WIDTH-1:0] UMax = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] UMin = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] SMax = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMin = {1'b1, {(WIDTH-1){1'b0}}};

    op_e              op_sel;
    logic             accept;

    logic             valid_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q;
    logic             ovf_q;
    logic             zero_q;
    logic [WIDTH-1:0] acc_q;

    logic [WIDTH-1:0] x_op;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH:0]   raw_ext;
    logic             is_add;
    logic             sx;
    logic             sy;
    logic             sr;
    logic [WIDTH-1:0] sat_val;
    logic [WIDTH-1:0] result_d;
    logic             carry_d;
    logic             ovf_d;
    logic             zero_d;

    assign op_sel   = op_e'(op);
    // Single output register: a new beat may enter whenever the current one leaves
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    assign out_valid = valid_q;
    assign result    = result_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign acc       = acc_q;

    // Datapath: raw add/subtract, carry/borrow, overflow and clamping
    always_comb begin
        x_op     = (op_sel == OpAccSub) ? acc_q : a;
        is_add   = (op_sel == OpAdd);
        sum_ext  = {1'b0, x_op} + {1'b0, b};
        diff_ext = {1'b0, x_op} - {1'b0, b};
        raw_ext  = is_add ? sum_ext : diff_ext;

        // Bit WIDTH is the carry-out for ADD and the borrow (X < Y) for subtracts
        carry_d = raw_ext[WIDTH];

        sx = x_op[WIDTH-1];
        sy = b[WIDTH-1];
        sr = raw_ext[WIDTH-1];

        if (IsSigned) begin
            if (is_add) begin
                ovf_d = (sx == sy) && (sr != sx);
            end else begin
                ovf_d = (sx != sy) && (sr != sx);
            end
        end else begin
            ovf_d = carry_d;
        end

        // On signed overflow the true result always has the sign of X
        if (IsSigned) begin
            sat_val = sx ? SMin : SMax;
        end else begin
            sat_val = is_add ? UMax : UMin;
        end

        if (DoSat && ovf_d) begin
            result_d = sat_val;
        end else begin
            result_d = raw_ext[WIDTH-1:0];
        end

        if (op_sel == OpLoad) begin
            result_d = a;
            carry_d  = 1'b0;
            ovf_d    = 1'b0;
        end

        zero_d = (result_d == '0);
    end

    // Output register, flags and accumulator; all captured together on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            acc_q    <= '0;
        end else begin
            if (accept) begin
                valid_q  <= 1'b1;
                result_q <= result_d;
                carry_q  <= carry_d;
                ovf_q    <= ovf_d;
                zero_q   <= zero_d;
                acc_q    <= result_d;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule
